id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register with integrated load-use hazard detection. Latches the decode
//  control bits (aluop/alusrc/regwrite/memtoreg/memread/memwrite/branch), operands, imm,
//  funct and rd from ID and presents them to EX one cycle later.
//  Detects a load-use hazard against the instruction held in EX, stalls PC and IF/ID,
//  and inserts a bubble. Keeps a saturating stall-cycle counter for debug.
// PARAMETERS
//  XLEN         32  data/PC width
//  STALL_CNT_W  16  width of stall-cycle counter
// PORTS
//  clk_i          in   1      clock, all state on rising edge
//  rst_n_i        in   1      reset, asynchronous, active-low
//  flush_i        in   1      kill instruction entering EX: load a bubble next edge
//  id_pc_i        in   XLEN   PC of ID instruction
//  id_rs1_i       in   5      rs1 index of ID instruction
//  id_rs2_i       in   5      rs2 index of ID instruction
//  id_rd_i        in   5      rd index of ID instruction
//  id_rs1data_i   in   XLEN   register-file read 1
//  id_rs2data_i   in   XLEN   register-file read 2
//  id_imm_i       in   XLEN   sign-extended immediate
//  id_funct_i     in   10     {funct7,funct3}
//  id_aluop_i     in   2      control: ALU op class
//  id_alusrc_i, id_regwrite_i, id_memtoreg_i, id_memread_i, id_memwrite_i, id_branch_i
//                 in   1 each decode control bits
//  ex_*_o         out  as in  registered copy of each id_*_i above (same names, ex_ prefix)
//  ex_valid_o     out  1      1 = EX holds a real instruction, 0 = bubble
//  stall_o        out  1      hold PC and IF/ID this cycle (combinational)
//  stall_cnt_o    out  STALL_CNT_W  saturating count of cycles with stall_o=1
// BEHAVIOUR
//  - Reset (rst_n_i=0, any time, async): every ex_*_o, ex_valid_o, stall_cnt_o = 0;
//    stall_o = 0 as a consequence (ex_memread_o=0). Mid-operation reset discards contents.
//  - hazard = ex_memread_o & ex_valid_o & (ex_rd_o != 0) &
//             ((ex_rd_o == id_rs1_i) | (ex_rd_o == id_rs2_i)); stall_o = hazard.
//    rs1/rs2 compared unconditionally (conservative; no per-format use decode).
//  - Each rising edge, priority:
//    1. bubble = flush_i | hazard: all 7 control outputs, ex_rd_o and ex_valid_o <= 0;
//       data fields (pc, rs1data, rs2data, imm, funct, rs1, rs2) <= ID values (don't-care
//       downstream but deterministic).
//    2. else: all ex_*_o <= id_*_i, ex_valid_o <= 1.
//  - Latency: ID -> EX exactly 1 cycle. No hold mode; bubble replaces the ID/EX contents.
//  - Bubble clears ex_memread_o, so stall_o drops the next cycle: each load-use hazard
//    costs exactly 1 stall cycle. Back-to-back load-use pairs each stall once.
//  - flush_i and hazard together: single bubble; stall_o still 1 (IF/ID holds).
//  - stall_cnt_o: +1 on each edge where stall_o=1; holds at all-ones (no wrap).
//  - rd = x0 never triggers a stall.
// TESTING
//  1. Reset release, ID: addi rd=5 rs1=1 imm=7, regwrite=1 alusrc=1 -> next edge
//     ex_rd_o=5, ex_imm_o=7, ex_regwrite_o=1, ex_valid_o=1, stall_o=0.
//  2. lw x5 then add x6,x5,x2 -> stall_o=1 for 1 cycle; next EX is bubble (all ctrl 0,
//     ex_valid_o=0); the following edge captures the add; stall_cnt_o=1.
//  3. lw x0 then add x6,x0,x2 -> stall_o stays 0, no bubble.
//  4. lw x5 then sw x5,0(x7) (match on rs2) -> one stall, stall_cnt_o increments.
//  5. flush_i=1 with a valid sw in ID -> ex_memwrite_o=0, ex_valid_o=0 next edge.
//  6. STALL_CNT_W=2, 5 load-use pairs -> stall_cnt_o saturates at 3;
//     assert rst_n_i mid-stall -> all outputs 0 immediately, before next edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with load-use hazard detection, bubble
//            insertion and a saturating stall-cycle counter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
   parameter int XLEN        = 32,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   flush_i,
   input  logic [XLEN-1:0]        id_pc_i,
   input  logic [4:0]             id_rs1_i,
   input  logic [4:0]             id_rs2_i,
   input  logic [4:0]             id_rd_i,
   input  logic [XLEN-1:0]        id_rs1data_i,
   input  logic [XLEN-1:0]        id_rs2data_i,
   input  logic [XLEN-1:0]        id_imm_i,
   input  logic [9:0]             id_funct_i,
   input  logic [1:0]             id_aluop_i,
   input  logic                   id_alusrc_i,
   input  logic                   id_regwrite_i,
   input  logic                   id_memtoreg_i,
   input  logic                   id_memread_i,
   input  logic                   id_memwrite_i,
   input  logic                   id_branch_i,
   output logic [XLEN-1:0]        ex_pc_o,
   output logic [4:0]             ex_rs1_o,
   output logic [4:0]             ex_rs2_o,
   output logic [4:0]             ex_rd_o,
   output logic [XLEN-1:0]        ex_rs1data_o,
   output logic [XLEN-1:0]        ex_rs2data_o,
   output logic [XLEN-1:0]        ex_imm_o,
   output logic [9:0]             ex_funct_o,
   output logic [1:0]             ex_aluop_o,
   output logic                   ex_alusrc_o,
   output logic                   ex_regwrite_o,
   output logic                   ex_memtoreg_o,
   output logic                   ex_memread_o,
   output logic                   ex_memwrite_o,
   output logic                   ex_branch_o,
   output logic                   ex_valid_o,
   output logic                   stall_o,
   output logic [STALL_CNT_W-1:0] stall_cnt_o
);

   localparam logic [STALL_CNT_W-1:0] c_CNT_MAX = '1;
   localparam logic [STALL_CNT_W-1:0] c_CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

   logic [XLEN-1:0]        r_pc;
   logic [4:0]             r_rs1;
   logic [4:0]             r_rs2;
   logic [4:0]             r_rd;
   logic [XLEN-1:0]        r_rs1data;
   logic [XLEN-1:0]        r_rs2data;
   logic [XLEN-1:0]        r_imm;
   logic [9:0]             r_funct;
   logic [1:0]             r_aluop;
   logic                   r_alusrc;
   logic                   r_regwrite;
   logic                   r_memtoreg;
   logic                   r_memread;
   logic                   r_memwrite;
   logic                   r_branch;
   logic                   r_valid;
   logic [STALL_CNT_W-1:0] r_stall_cnt;

   logic w_hazard;
   logic w_bubble;

   // rs1/rs2 are compared regardless of instruction format, so an unused
   // source field that happens to match costs one spurious stall cycle.
   assign w_hazard = r_memread & r_valid & (r_rd != 5'd0) &
                     ((r_rd == id_rs1_i) | (r_rd == id_rs2_i));
   assign w_bubble = flush_i | w_hazard;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_pc        <= '0;
         r_rs1       <= '0;
         r_rs2       <= '0;
         r_rd        <= '0;
         r_rs1data   <= '0;
         r_rs2data   <= '0;
         r_imm       <= '0;
         r_funct     <= '0;
         r_aluop     <= '0;
         r_alusrc    <= 1'b0;
         r_regwrite  <= 1'b0;
         r_memtoreg  <= 1'b0;
         r_memread   <= 1'b0;
         r_memwrite  <= 1'b0;
         r_branch    <= 1'b0;
         r_valid     <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         // Data fields follow ID even on a bubble so EX contents stay deterministic.
         r_pc      <= id_pc_i;
         r_rs1     <= id_rs1_i;
         r_rs2     <= id_rs2_i;
         r_rs1data <= id_rs1data_i;
         r_rs2data <= id_rs2data_i;
         r_imm     <= id_imm_i;
         r_funct   <= id_funct_i;
         if (w_bubble) begin
            r_rd       <= '0;
            r_aluop    <= '0;
            r_alusrc   <= 1'b0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_branch   <= 1'b0;
            r_valid    <= 1'b0;
         end else begin
            r_rd       <= id_rd_i;
            r_aluop    <= id_aluop_i;
            r_alusrc   <= id_alusrc_i;
            r_regwrite <= id_regwrite_i;
            r_memtoreg <= id_memtoreg_i;
            r_memread  <= id_memread_i;
            r_memwrite <= id_memwrite_i;
            r_branch   <= id_branch_i;
            r_valid    <= 1'b1;
         end
         if (w_hazard && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
         end
      end
   end

   assign ex_pc_o       = r_pc;
   assign ex_rs1_o      = r_rs1;
   assign ex_rs2_o      = r_rs2;
   assign ex_rd_o       = r_rd;
   assign ex_rs1data_o  = r_rs1data;
   assign ex_rs2data_o  = r_rs2data;
   assign ex_imm_o      = r_imm;
   assign ex_funct_o    = r_funct;
   assign ex_aluop_o    = r_aluop;
   assign ex_alusrc_o   = r_alusrc;
   assign ex_regwrite_o = r_regwrite;
   assign ex_memtoreg_o = r_memtoreg;
   assign ex_memread_o  = r_memread;
   assign ex_memwrite_o = r_memwrite;
   assign ex_branch_o   = r_branch;
   assign ex_valid_o    = r_valid;
   assign stall_o       = w_hazard;
   assign stall_cnt_o   = r_stall_cnt;

endmodule

`default_nettype wire
